clut_loader: RTL and testbench

//  Fetches a palette (CLUT) from VRAM and fills the CLUT cache when the cache reports a miss.

---
 rtl/clut_loader.sv | 116 +++++++++++
 tb/tb_clut_loader.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/clut_loader.sv
// rtl/clut_loader.sv - fetches a 16- or 256-colour palette from VRAM in 8-word bursts
// and drives the CLUT cache write port.
module clut_loader #(
  parameter int BURST_LOG2 = 3
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_loadReq,
  input  logic [14:0] i_CLUT_ID,
  input  logic        i_is8bpp,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_memReq,
  output logic [17:0] o_memAddr,
  input  logic        i_memAck,
  input  logic        i_memDataValid,
  input  logic [31:0] i_memData,
  output logic        o_write,
  output logic [6:0]  o_writeIdx128,
  output logic [31:0] o_Colors
);

  localparam int BEATS = 1 << BURST_LOG2;
  localparam logic [2:0] LAST_BEAT = 3'(BEATS - 1);

  typedef enum logic [1:0] {IDLE, REQ, RECV, DONE} state_t;

  state_t     state;
  logic [8:0] row;
  logic [5:0] x;
  logic       is8;
  logic [3:0] b;
  logic [2:0] k;
  logic [5:0] col_next;
  logic [3:0] last_b;

  // Column advances in 8-word steps and wraps inside the same VRAM row.
  always_comb begin
    col_next = 6'd0;
    last_b   = 4'd0;
    col_next = x + {2'b00, b} + 6'd1;
    last_b   = is8 ? 4'd15 : 4'd0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      row           <= 9'd0;
      x             <= 6'd0;
      is8           <= 1'b0;
      b             <= 4'd0;
      k             <= 3'd0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
      o_memReq      <= 1'b0;
      o_memAddr     <= 18'd0;
      o_write       <= 1'b0;
      o_writeIdx128 <= 7'd0;
      o_Colors      <= 32'd0;
    end else begin
      o_write <= 1'b0;
      o_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (i_loadReq) begin
            row       <= i_CLUT_ID[14:6];
            x         <= i_CLUT_ID[5:0];
            is8       <= i_is8bpp;
            b         <= 4'd0;
            k         <= 3'd0;
            o_busy    <= 1'b1;
            o_memReq  <= 1'b1;
            o_memAddr <= {i_CLUT_ID[14:6], i_CLUT_ID[5:0], 3'b000};
            state     <= REQ;
          end
        end
        REQ: begin
          if (i_memAck) begin
            o_memReq <= 1'b0;
            state    <= RECV;
          end
        end
        RECV: begin
          if (i_memDataValid) begin
            o_write       <= 1'b1;
            o_writeIdx128 <= {b, k};
            o_Colors      <= i_memData;
            k             <= k + 3'd1;
            if (k == LAST_BEAT) begin
              k <= 3'd0;
              if (b == last_b) begin
                state <= DONE;
              end else begin
                b         <= b + 4'd1;
                o_memReq  <= 1'b1;
                o_memAddr <= {row, col_next, 3'b000};
                state     <= REQ;
              end
            end
          end
        end
        DONE: begin
          // First DONE cycle carries the final write; the second raises o_done.
          if (!o_done) begin
            o_done <= 1'b1;
          end else begin
            o_busy <= 1'b0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clut_loader.sv
// tb/tb_clut_loader.sv - table-driven bench for clut_loader palette loads.
module tb_clut_loader;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_loadReq = 1'b0;
  logic [14:0] i_CLUT_ID = 15'd0;
  logic        i_is8bpp = 1'b0;
  logic        o_busy, o_done, o_memReq, o_write;
  logic [17:0] o_memAddr;
  logic        i_memAck = 1'b0;
  logic        i_memDataValid = 1'b0;
  logic [31:0] i_memData = 32'd0;
  logic [6:0]  o_writeIdx128;
  logic [31:0] o_Colors;

  always #5 clk = ~clk;

  clut_loader dut (
    .i_clk(clk), .i_rst(i_rst), .i_loadReq(i_loadReq), .i_CLUT_ID(i_CLUT_ID),
    .i_is8bpp(i_is8bpp), .o_busy(o_busy), .o_done(o_done), .o_memReq(o_memReq),
    .o_memAddr(o_memAddr), .i_memAck(i_memAck), .i_memDataValid(i_memDataValid),
    .i_memData(i_memData), .o_write(o_write), .o_writeIdx128(o_writeIdx128),
    .o_Colors(o_Colors)
  );

  int compared = 0;
  int mismatched = 0;

  int          cyc = 0;
  int          last_wr = -10;
  int          wr_idx[$];
  logic [31:0] wr_dat[$];
  int          req_cnt, done_cnt, done_ok, stab_err;
  logic        prev_req = 1'b0;
  logic [17:0] prev_addr = 18'd0;

  always @(negedge clk) begin
    cyc++;
    if (o_done) begin
      done_cnt++;
      if (last_wr == cyc - 1 && o_busy && !o_write) done_ok++;
    end
    if (o_write) begin
      wr_idx.push_back(int'(o_writeIdx128));
      wr_dat.push_back(o_Colors);
      last_wr = cyc;
    end
    if (o_memReq && !prev_req) req_cnt++;
    if (o_memReq && prev_req && o_memAddr != prev_addr) stab_err++;
    prev_req  = o_memReq;
    prev_addr = o_memAddr;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, o_busy, 0);
    check({tag, "_done"}, o_done, 0);
    check({tag, "_memreq"}, o_memReq, 0);
    check({tag, "_write"}, o_write, 0);
    check({tag, "_addr"}, o_memAddr, 0);
    check({tag, "_idx"}, o_writeIdx128, 0);
    check({tag, "_colors"}, o_Colors, 0);
  endtask

  typedef struct {
    logic        is8;
    logic [8:0]  y;
    logic [5:0]  x;
    int          dly;
    bit          gap;
    bit          inj;
    bit          stray;
    int          rst_b;
    int          rst_k;
    logic [31:0] seed;
  } vec_t;

  task automatic run_load(input vec_t v);
    int          nb, nexp, nreq_exp, cnt;
    logic [17:0] exp_addr;
    bit          aborted;
    nb = v.is8 ? 16 : 1;
    wr_idx.delete();
    wr_dat.delete();
    req_cnt = 0; done_cnt = 0; done_ok = 0; stab_err = 0;
    if (v.stray) begin
      i_memDataValid = 1'b1;
      i_memData = 32'hDEADBEEF;
      repeat (2) @(posedge clk);
      #1 i_memDataValid = 1'b0;
    end
    check("busy_idle", o_busy, 0);
    i_CLUT_ID = {v.y, v.x};
    i_is8bpp = v.is8;
    i_loadReq = 1'b1;
    @(posedge clk); #1;
    i_loadReq = 1'b0;
    i_CLUT_ID = 15'h7fff;
    i_is8bpp = ~v.is8;
    check("busy_rise", o_busy, 1);
    aborted = 1'b0;
    for (int b = 0; b < nb && !aborted; b++) begin
      cnt = 0;
      while (!o_memReq && cnt < 20) begin
        @(posedge clk); #1;
        cnt++;
      end
      check("req_seen", o_memReq, 1);
      if (!o_memReq) return;
      exp_addr = {v.y, 9'((int'(v.x) * 8 + b * 8) % 512)};
      check("req_addr", o_memAddr, exp_addr);
      repeat (v.dly) begin
        @(posedge clk); #1;
      end
      i_memAck = 1'b1;
      @(posedge clk); #1;
      i_memAck = 1'b0;
      for (int k = 0; k < 8; k++) begin
        if (v.gap) repeat (1 + k % 3) begin
          @(posedge clk); #1;
        end
        i_memDataValid = 1'b1;
        i_memData = v.seed + 32'(b * 8 + k);
        if (v.inj && k == 4) begin
          i_loadReq = 1'b1;
          i_CLUT_ID = 15'h1234;
        end
        @(posedge clk); #1;
        i_memDataValid = 1'b0;
        i_loadReq = 1'b0;
        if (b == v.rst_b && k == v.rst_k) begin
          i_rst = 1'b1;
          @(posedge clk); #1;
          i_rst = 1'b0;
          check_zero("midrst");
          aborted = 1'b1;
          break;
        end
      end
    end
    cnt = 0;
    while (o_busy && cnt < 20) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("busy_fall", o_busy, 0);
    repeat (3) @(posedge clk);
    #1;
    nexp     = aborted ? v.rst_b * 8 + v.rst_k + 1 : nb * 8;
    nreq_exp = aborted ? v.rst_b + 1 : nb;
    check("write_count", wr_idx.size(), nexp);
    for (int n = 0; n < nexp && n < wr_idx.size(); n++) begin
      check("write_idx", wr_idx[n], n);
      check("write_data", wr_dat[n], v.seed + 32'(n));
    end
    check("req_count", req_cnt, nreq_exp);
    check("done_count", done_cnt, aborted ? 0 : 1);
    check("done_timing", done_ok, aborted ? 0 : 1);
    check("addr_stable", stab_err, 0);
  endtask

  vec_t vecs[7];

  initial begin
    // is8, y, x, dly, gap, inj, stray, rst_b, rst_k, seed
    vecs[0] = '{1'b0, 9'd5,   6'd3,  0, 1'b0, 1'b0, 1'b0, -1, -1, 32'h0001_0000};
    vecs[1] = '{1'b1, 9'd480, 6'd0,  0, 1'b0, 1'b0, 1'b0, -1, -1, 32'hA500_0000};
    vecs[2] = '{1'b1, 9'd480, 6'd62, 0, 1'b0, 1'b0, 1'b0, -1, -1, 32'h5A00_0000};
    vecs[3] = '{1'b0, 9'd100, 6'd17, 5, 1'b1, 1'b0, 1'b0, -1, -1, 32'h1234_0000};
    vecs[4] = '{1'b0, 9'd7,   6'd40, 2, 1'b0, 1'b1, 1'b1, -1, -1, 32'h0BAD_0000};
    vecs[5] = '{1'b1, 9'd3,   6'd1,  0, 1'b0, 1'b0, 1'b0,  2,  3, 32'h7700_0000};
    vecs[6] = '{1'b1, 9'd9,   6'd63, 1, 1'b1, 1'b0, 1'b0, -1, -1, 32'h3300_0000};

    repeat (2) @(posedge clk);
    #1;
    check_zero("reset");
    i_rst = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 7; i++) run_load(vecs[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
